// File: rtl/timeset_button_ctrl.sv
// Time-set button front end: synchronizes and debounces the hour/minute set
// buttons and turns divider strobes into slow-then-fast increment pulses.
module timeset_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int SLOW_COUNT      = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_set_hr,
    input  logic i_set_min,
    input  logic i_timeset_stb,
    output logic o_div_en,
    output logic o_fast_set,
    output logic o_hr_inc,
    output logic o_min_inc,
    output logic o_setting
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(SLOW_COUNT + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] SLOW_MAX = CW'(SLOW_COUNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SLOW = 2'd1;
    localparam logic [1:0] ST_FAST = 2'd2;

    localparam int B_HR  = 1;
    localparam int B_MIN = 0;

    logic [1:0]    raw_s;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_prev_q;
    logic [DW-1:0] deb_cnt_q [2];

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc_s;
    logic          hr_inc_q, hr_inc_d;
    logic          min_inc_q, min_inc_d;
    logic          div_en_q, fast_q;
    logic          hr_rise_s, min_rise_s, sel_lvl_s;

    assign raw_s = {i_set_hr, i_set_min};

    // Two-stage synchronizer and per-button debounce counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            db_q      <= 2'b00;
            db_prev_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                deb_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] != db_q[b]) begin
                    if (deb_cnt_q[b] == DB_LAST) begin
                        db_q[b]      <= sync2_q[b];
                        deb_cnt_q[b] <= '0;
                    end else begin
                        deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[b] <= '0;
                end
            end
        end
    end

    assign hr_rise_s  = db_q[B_HR] & ~db_prev_q[B_HR];
    assign min_rise_s = db_q[B_MIN] & ~db_prev_q[B_MIN];
    assign sel_lvl_s  = sel_q ? db_q[B_HR] : db_q[B_MIN];
    assign cnt_inc_s  = (cnt_q == SLOW_MAX) ? cnt_q : cnt_q + 1'b1;

    // Set-mode FSM; a release of the selected button takes priority over a strobe.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        hr_inc_d  = 1'b0;
        min_inc_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hr_rise_s && !db_q[B_MIN]) begin
                    sel_d    = 1'b1;
                    hr_inc_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SLOW;
                end else if (min_rise_s && !db_q[B_HR]) begin
                    sel_d     = 1'b0;
                    min_inc_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_SLOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SLOW, ST_FAST: begin
                if (!sel_lvl_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (i_timeset_stb) begin
                    hr_inc_d  = sel_q;
                    min_inc_d = ~sel_q;
                    if (state_q == ST_SLOW) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == SLOW_MAX) begin
                            state_d = ST_FAST;
                        end else begin
                            state_d = ST_SLOW;
                        end
                    end else begin
                        state_d = ST_FAST;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            hr_inc_q  <= 1'b0;
            min_inc_q <= 1'b0;
            div_en_q  <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            hr_inc_q  <= hr_inc_d;
            min_inc_q <= min_inc_d;
            div_en_q  <= (state_d != ST_IDLE);
            fast_q    <= (state_d == ST_FAST);
        end
    end

    assign o_div_en   = div_en_q;
    assign o_setting  = div_en_q;
    assign o_fast_set = fast_q;
    assign o_hr_inc   = hr_inc_q;
    assign o_min_inc  = min_inc_q;

endmodule

// File: tb/tb_timeset_button_ctrl.sv
// Directed bench for timeset_button_ctrl with a short debounce and slow phase.
module tb_timeset_button_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic set_hr, set_min, stb;
    logic div_en, fast_set, hr_inc, min_inc, setting;

    int checks = 0;
    int passed = 0;
    int hr_cnt = 0;
    int min_cnt = 0;
    int overlap_err = 0;
    int consec_err = 0;
    logic prev_hr = 1'b0;
    logic prev_min = 1'b0;

    timeset_button_ctrl #(.DEBOUNCE_CYCLES(4), .SLOW_COUNT(3)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_set_hr(set_hr), .i_set_min(set_min),
        .i_timeset_stb(stb), .o_div_en(div_en), .o_fast_set(fast_set),
        .o_hr_inc(hr_inc), .o_min_inc(min_inc), .o_setting(setting)
    );

    always #5 clk = ~clk;

    // Pulse accounting and pulse-shape monitoring, sampled mid-cycle.
    always @(negedge clk) begin
        if (hr_inc === 1'b1) hr_cnt++;
        if (min_inc === 1'b1) min_cnt++;
        if (hr_inc === 1'b1 && min_inc === 1'b1) overlap_err++;
        if ((prev_hr && hr_inc === 1'b1) || (prev_min && min_inc === 1'b1)) consec_err++;
        prev_hr  <= (hr_inc === 1'b1);
        prev_min <= (min_inc === 1'b1);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, "_outs"}, {27'd0, div_en, fast_set, hr_inc, min_inc, setting}, 32'd0);
    endtask

    task automatic strobe();
        stb = 1'b1;
        tick();
        stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; set_hr = 1'b0; set_min = 1'b0; stb = 1'b0;
        // 1. reset and idle
        tick(2);
        chk_all0("reset");
        rst_n = 1'b1;
        tick(20);
        chk_all0("idle20");
        chk("idle_pulses", hr_cnt + min_cnt, 32'd0);

        // 2. three-cycle glitch on min
        set_min = 1'b1;
        tick(3);
        set_min = 1'b0;
        tick(10);
        chk("glitch_div_en", div_en, 1'b0);
        chk("glitch_pulses", min_cnt, 32'd0);

        // 3. hold min: immediate step, 3 slow strobes, then fast
        set_min = 1'b1;
        tick(6);
        chk("press_before", min_inc, 1'b0);
        tick();
        chk("press_min_inc", min_inc, 1'b1);
        chk("press_div_en", div_en, 1'b1);
        chk("press_setting", setting, 1'b1);
        chk("press_fast", fast_set, 1'b0);
        tick();
        chk("press_single", min_inc, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            strobe();
            chk("stb_min_inc", min_inc, 1'b1);
            chk("stb_fast", fast_set, (k >= 3) ? 1'b1 : 1'b0);
            tick();
            chk("stb_single", min_inc, 1'b0);
        end
        chk("min_total6", min_cnt, 32'd6);

        // 4. release coinciding with a strobe
        set_min = 1'b0;
        tick(6);
        chk("rel_still_active", div_en, 1'b1);
        strobe();
        chk("rel_no_pulse", min_inc, 1'b0);
        chk_all0("released");
        tick(3);
        chk("rel_min_total", min_cnt, 32'd6);

        // 5. both together, then hr alone with min added later
        set_hr = 1'b1; set_min = 1'b1;
        tick(12);
        chk("both_div_en", div_en, 1'b0);
        chk("both_hr_cnt", hr_cnt, 32'd0);
        set_hr = 1'b0; set_min = 1'b0;
        tick(10);
        set_hr = 1'b1;
        tick(6);
        chk("hr_before", hr_inc, 1'b0);
        tick();
        chk("hr_press_inc", hr_inc, 1'b1);
        tick(3);
        set_min = 1'b1;
        tick(10);
        chk("hr_min_ignored", div_en, 1'b1);
        for (int k = 0; k < 2; k++) begin
            strobe();
            chk("hr_stb_inc", hr_inc, 1'b1);
            chk("hr_stb_no_min", min_inc, 1'b0);
            tick();
        end
        chk("hr_total3", hr_cnt, 32'd3);
        chk("min_still6", min_cnt, 32'd6);
        chk("hr_slow", fast_set, 1'b0);

        // 6. reach fast, then async reset with hr held
        strobe();
        chk("hr_fast_inc", hr_inc, 1'b1);
        chk("hr_fast", fast_set, 1'b1);
        tick();
        set_min = 1'b0;
        tick(10);
        chk("min_rel_ignored", fast_set, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all0("async_reset");
        tick(3);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_wait", {30'd0, hr_inc, div_en}, 32'd0);
        tick();
        chk("post_rst_inc", hr_inc, 1'b1);
        chk("post_rst_div_en", div_en, 1'b1);
        chk("post_rst_fast", fast_set, 1'b0);
        tick();
        strobe();
        chk("post_rst_stb", hr_inc, 1'b1);
        chk("post_rst_slow", fast_set, 1'b0);
        tick();
        chk("hr_total6", hr_cnt, 32'd6);
        chk("min_total_end", min_cnt, 32'd6);
        chk("overlap", overlap_err, 32'd0);
        chk("consecutive", consec_err, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
